uart_rx_word_assembler: RTL

Receive-side counterpart of the word-to-byte transmit buffer. It collects bytes delivered by the UART receiver, packs every DATA_BITS/8 consecutive bytes little-endian into one word, and writes that word into the receive FIFO. It sits between the UART receiver and the RX FIFO. It also reports FIFO overflow and can optionally discard a partial word after an inter-byte timeout.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_idle_timer.sv | 30 +++
 rtl/uart_rx_word_assembler.sv | 139 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive word assembler: state encoding,
// byte width and word-geometry helpers.
package uart_pkg;

  localparam int unsigned UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUSH,
    HOLD
  } rx_asm_state_e;

  function automatic int unsigned calc_nb(input int unsigned data_bits);
    return data_bits / UART_BYTE_W;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned data_bits);
    int unsigned nb;
    nb = data_bits / UART_BYTE_W;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_idle_timer.sv
// Inter-byte idle counter: clears on a byte, counts while enabled and
// flags expiry in the cycle the count reaches LIMIT-1 with no byte.
module uart_rx_idle_timer #(
  parameter int unsigned LIMIT = 100000
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int unsigned TW = $clog2(LIMIT);
  localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);

  logic [TW-1:0] r_count;

  assign o_expire = i_enable && !i_clear && (r_count == LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_count <= '0;
    end else if (i_clear || !i_enable || o_expire) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_word_assembler.sv
// Packs received UART bytes little-endian into DATA_BITS words for the RX FIFO.
// Optional partial-word timeout is built only when UART_RX_ASM_TIMEOUT_EN is defined.
module uart_rx_word_assembler
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS      = 32,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_rx_done,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_fifo_full,
  output logic                 o_fifo_wr,
  output logic [DATA_BITS-1:0] o_fifo_data,
  output logic                 o_overflow,
  input  logic                 i_clear_overflow,
  output logic                 o_busy,
  output logic                 o_timeout
);

  localparam int unsigned    NB   = calc_nb(DATA_BITS);
  localparam int unsigned    CW   = calc_cnt_w(DATA_BITS);
  localparam logic [CW-1:0]  LAST = CW'(NB - 1);

  if ((DATA_BITS % UART_BYTE_W) != 0 || DATA_BITS < 16) begin : g_bad_data_bits
    $error("DATA_BITS must be a multiple of 8 and at least 16");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  rx_asm_state_e          r_state;
  logic [CW-1:0]          r_cnt;
  logic [DATA_BITS-1:0]   r_asm;
  logic [DATA_BITS-1:0]   r_fifo_data;
  logic                   r_fifo_wr;
  logic                   r_overflow;
  logic                   r_timeout;
  logic                   w_expire;

`ifdef UART_RX_ASM_TIMEOUT_EN
  uart_rx_idle_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_clear  (i_rx_done),
    .i_enable (r_state == COLLECT),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_asm       <= '0;
      r_fifo_data <= '0;
      r_fifo_wr   <= 1'b0;
      r_overflow  <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_fifo_wr <= 1'b0;
      r_timeout <= 1'b0;

      // A byte dropped in HOLD outranks a simultaneous clear.
      if (r_state == HOLD && i_rx_done) begin
        r_overflow <= 1'b1;
      end else if (i_clear_overflow) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (i_rx_done) begin
            r_asm[UART_BYTE_W-1:0] <= i_rx_data;
            r_cnt                  <= CW'(1);
            r_state                <= COLLECT;
          end
        end

        COLLECT: begin
          if (i_rx_done) begin
            r_asm[UART_BYTE_W*r_cnt +: UART_BYTE_W] <= i_rx_data;
            if (r_cnt == LAST) begin
              r_fifo_data <= {i_rx_data, r_asm[DATA_BITS-UART_BYTE_W-1:0]};
              r_cnt       <= '0;
              if (!i_fifo_full) begin
                r_state   <= PUSH;
                r_fifo_wr <= 1'b1;
              end else begin
                r_state   <= HOLD;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else if (w_expire) begin
            r_cnt     <= '0;
            r_state   <= IDLE;
            r_timeout <= 1'b1;
          end
        end

        PUSH: begin
          // Output word lives in its own register, so the next word can start here.
          if (i_rx_done) begin
            r_asm[UART_BYTE_W-1:0] <= i_rx_data;
            r_cnt                  <= CW'(1);
            r_state                <= COLLECT;
          end else begin
            r_state <= IDLE;
          end
        end

        HOLD: begin
          if (!i_fifo_full) begin
            r_state   <= PUSH;
            r_fifo_wr <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_fifo_wr   = r_fifo_wr;
  assign o_fifo_data = r_fifo_data;
  assign o_overflow  = r_overflow;
  assign o_busy      = (r_state != IDLE);
  assign o_timeout   = r_timeout;

endmodule
